hls_deadlock_report_unit: RTL

HLS_DEADLOCK_REPORT_UNIT -- requirements
Module: hls_deadlock_report_unit

---
 rtl/hls_deadlock_pkg.sv | 21 ++
 rtl/hls_deadlock_prio_enc.sv | 22 ++
 rtl/hls_deadlock_report_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/hls_deadlock_pkg.sv
// Shared types and width helpers for the HLS deadlock report unit.
package hls_deadlock_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ARMING   = 2'd1,
        S_DEADLOCK = 2'd2,
        S_REPORTED = 2'd3
    } state_e;

    // Index width for a monitor vector; never narrower than one bit.
    function automatic int idx_w(input int num_mon);
        return (num_mon <= 1) ? 1 : $clog2(num_mon);
    endfunction

    // Arm counter only needs to reach thresh-1.
    function automatic int arm_w(input int thresh);
        return (thresh <= 2) ? 1 : $clog2(thresh);
    endfunction

endpackage

// File: rtl/hls_deadlock_prio_enc.sv
// Priority encoder: index of the least-significant set bit (0 when none set).
module hls_deadlock_prio_enc
    import hls_deadlock_pkg::*;
#(
    parameter int NUM_MON = 4
) (
    input  logic [NUM_MON-1:0]          i_vec,
    output logic [idx_w(NUM_MON)-1:0]   o_idx
);

    localparam int IDX_W = idx_w(NUM_MON);

    always_comb begin
        // NOTE: output defaulted before the loop so no path leaves it unassigned (no latch).
        o_idx = '0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (i_vec[i]) o_idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/hls_deadlock_report_unit.sv
// Declares deadlock after THRESH consecutive blocked cycles and holds a
// one-shot valid/ready report of which monitors were blocked at that moment.
module hls_deadlock_report_unit
    import hls_deadlock_pkg::*;
#(
    parameter int NUM_MON = 4,
    parameter int THRESH  = 16,
    parameter int CNT_W   = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_MON-1:0]          block_sigs,
    input  logic                        clear,
    output logic                        deadlock,
    output logic [idx_w(NUM_MON)-1:0]   deadlock_idx,
    output logic [NUM_MON-1:0]          first_mask,
    output logic [CNT_W-1:0]            block_cycles,
    output logic                        report_valid,
    input  logic                        report_ready
);

    localparam int IDX_W = idx_w(NUM_MON);
    localparam int ARM_W = arm_w(THRESH);

    state_e               r_state;
    logic [ARM_W-1:0]     r_arm_cnt;
    logic [CNT_W-1:0]     r_block_cycles;
    logic [NUM_MON-1:0]   r_first_mask;
    logic [IDX_W-1:0]     r_deadlock_idx;

    state_e               w_state_nxt;
    logic [ARM_W-1:0]     w_arm_cnt_nxt;
    logic [CNT_W-1:0]     w_block_cycles_nxt;
    logic [CNT_W-1:0]     w_block_cycles_inc;
    logic [NUM_MON-1:0]   w_first_mask_nxt;
    logic [IDX_W-1:0]     w_deadlock_idx_nxt;
    logic [IDX_W-1:0]     w_enc_idx;
    logic                 w_any;

    hls_deadlock_prio_enc #(.NUM_MON(NUM_MON)) u_prio_enc (
        .i_vec (block_sigs),
        .o_idx (w_enc_idx)
    );

    assign w_any              = |block_sigs;
    assign w_block_cycles_inc = (r_block_cycles == '1) ? r_block_cycles
                                                       : r_block_cycles + CNT_W'(1);

    always_comb begin
        w_state_nxt        = r_state;
        w_arm_cnt_nxt      = r_arm_cnt;
        w_block_cycles_nxt = r_block_cycles;
        w_first_mask_nxt   = r_first_mask;
        w_deadlock_idx_nxt = r_deadlock_idx;

        // Clear wins over every transition, including the report handshake.
        if (clear) begin
            w_state_nxt        = S_IDLE;
            w_arm_cnt_nxt      = '0;
            w_block_cycles_nxt = '0;
            w_first_mask_nxt   = '0;
            w_deadlock_idx_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        w_state_nxt        = S_ARMING;
                        w_arm_cnt_nxt      = ARM_W'(1);
                        w_block_cycles_nxt = CNT_W'(1);
                    end
                end
                S_ARMING: begin
                    if (!w_any) begin
                        w_state_nxt        = S_IDLE;
                        w_arm_cnt_nxt      = '0;
                        w_block_cycles_nxt = '0;
                    end else begin
                        w_block_cycles_nxt = w_block_cycles_inc;
                        if (r_arm_cnt == ARM_W'(THRESH - 1)) begin
                            w_state_nxt        = S_DEADLOCK;
                            w_first_mask_nxt   = block_sigs;
                            w_deadlock_idx_nxt = w_enc_idx;
                        end else begin
                            w_arm_cnt_nxt = r_arm_cnt + ARM_W'(1);
                        end
                    end
                end
                S_DEADLOCK: begin
                    if (w_any)        w_block_cycles_nxt = w_block_cycles_inc;
                    if (report_ready) w_state_nxt        = S_REPORTED;
                end
                S_REPORTED: begin
                    if (w_any) w_block_cycles_nxt = w_block_cycles_inc;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: every register here defines a visible output at reset, so all are reset synchronously.
        if (reset) begin
            r_state        <= S_IDLE;
            r_arm_cnt      <= '0;
            r_block_cycles <= '0;
            r_first_mask   <= '0;
            r_deadlock_idx <= '0;
        end else begin
            // NOTE: non-blocking so all registers update from the same pre-edge values.
            r_state        <= w_state_nxt;
            r_arm_cnt      <= w_arm_cnt_nxt;
            r_block_cycles <= w_block_cycles_nxt;
            r_first_mask   <= w_first_mask_nxt;
            r_deadlock_idx <= w_deadlock_idx_nxt;
        end
    end

    assign deadlock     = (r_state == S_DEADLOCK) || (r_state == S_REPORTED);
    assign report_valid = (r_state == S_DEADLOCK);
    assign first_mask   = r_first_mask;
    assign deadlock_idx = r_deadlock_idx;
    assign block_cycles = r_block_cycles;

endmodule
